// File: rtl/lsf_seq_pkg.sv
// Shared types and widths for the LSF event sequencer.
// HEG2SF*_LEN mirror the l0mdt bus constants header for the HEG -> SF interface.
package lsf_seq_pkg;

  localparam int HEG2SFSLC_LEN = 64;
  localparam int HEG2SFHIT_LEN = 40;
  localparam int HIST_CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSE,
    GAP
  } lsf_seq_state_t;

endpackage

// File: rtl/lsf_sat_counter.sv
// Saturating up-counter: increments by one per asserted inc, sticks at all-ones.
module lsf_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/lsf_event_sequencer.sv
// Frames HEG ROI and hit streams into one Legendre-engine event at a time:
// ROI, capped hits, then a one-cycle EOF with the event's hit count.
module lsf_event_sequencer
  import lsf_seq_pkg::*;
#(
  parameter int MAX_HITS      = 32,
  parameter int WINDOW_CYCLES = 256,
  parameter int MIN_GAP       = 4,
  parameter int CNT_W         = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [HEG2SFSLC_LEN-1:0] i_slc,
  input  logic                     i_slc_vld,
  input  logic [HEG2SFHIT_LEN-1:0] i_hit,
  input  logic                     i_hit_vld,
  input  logic                     i_heg_eof,
  output logic [HEG2SFSLC_LEN-1:0] o_roi,
  output logic                     o_roi_we,
  output logic [HEG2SFHIT_LEN-1:0] o_mdt_hit,
  output logic                     o_mdt_hit_we,
  output logic                     o_eof,
  output logic [HIST_CNT_W-1:0]    o_hist_count,
  output logic [CNT_W-1:0]         o_slc_drop_cnt,
  output logic [CNT_W-1:0]         o_hit_drop_cnt,
  output logic [CNT_W-1:0]         o_orphan_hit_cnt,
  output logic                     o_busy
);

  localparam int HIT_W   = $clog2(MAX_HITS + 1);
  localparam int TIMER_W = $clog2(WINDOW_CYCLES);
  localparam int GAP_W   = $clog2(MIN_GAP + 1);

  lsf_seq_state_t             state_q, state_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [HEG2SFSLC_LEN-1:0]   pend_roi_q, pend_roi_d;
  logic [HIT_W-1:0]           hit_cnt_q, hit_cnt_d;
  logic [TIMER_W-1:0]         timer_q, timer_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [HEG2SFSLC_LEN-1:0]   roi_q, roi_d;
  logic                       roi_we_q, roi_we_d;
  logic [HEG2SFHIT_LEN-1:0]   hit_q, hit_d;
  logic                       hit_we_q, hit_we_d;
  logic                       eof_q, eof_d;
  logic [HIST_CNT_W-1:0]      hist_q, hist_d;
  logic                       busy_q, busy_d;
  logic                       inc_slc_drop, inc_hit_drop, inc_orphan;

  always_comb begin
    state_d      = state_q;
    pend_vld_d   = pend_vld_q;
    pend_roi_d   = pend_roi_q;
    hit_cnt_d    = hit_cnt_q;
    timer_d      = timer_q;
    gap_cnt_d    = gap_cnt_q;
    roi_d        = roi_q;
    roi_we_d     = 1'b0;
    hit_d        = hit_q;
    hit_we_d     = 1'b0;
    eof_d        = 1'b0;
    hist_d       = hist_q;
    inc_slc_drop = 1'b0;
    inc_hit_drop = 1'b0;
    inc_orphan   = i_hit_vld && (state_q != OPEN);

    unique case (state_q)
      IDLE: begin
        // A held ROI goes first; a same-cycle new ROI refills the slot it vacates.
        if (pend_vld_q || i_slc_vld) begin
          roi_d      = pend_vld_q ? pend_roi_q : i_slc;
          roi_we_d   = 1'b1;
          hit_cnt_d  = '0;
          timer_d    = '0;
          state_d    = OPEN;
          pend_vld_d = pend_vld_q && i_slc_vld;
          if (pend_vld_q && i_slc_vld) pend_roi_d = i_slc;
        end
      end
      OPEN: begin
        if (i_hit_vld) begin
          if (hit_cnt_q < HIT_W'(MAX_HITS)) begin
            hit_d     = i_hit;
            hit_we_d  = 1'b1;
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
          end else begin
            inc_hit_drop = 1'b1;
          end
        end
        timer_d = timer_q + TIMER_W'(1);
        if (i_heg_eof || (timer_q == TIMER_W'(WINDOW_CYCLES - 1))) state_d = CLOSE;
      end
      CLOSE: begin
        eof_d     = 1'b1;
        hist_d    = HIST_CNT_W'(hit_cnt_q);
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(MIN_GAP - 1)) state_d = IDLE;
        else                                 gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outside IDLE a new ROI can only wait in the single pending slot.
    if ((state_q != IDLE) && i_slc_vld) begin
      if (pend_vld_q) begin
        inc_slc_drop = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_roi_d = i_slc;
      end
    end

    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_roi_q <= '0;
      hit_cnt_q  <= '0;
      timer_q    <= '0;
      gap_cnt_q  <= '0;
      roi_q      <= '0;
      roi_we_q   <= 1'b0;
      hit_q      <= '0;
      hit_we_q   <= 1'b0;
      eof_q      <= 1'b0;
      hist_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_roi_q <= pend_roi_d;
      hit_cnt_q  <= hit_cnt_d;
      timer_q    <= timer_d;
      gap_cnt_q  <= gap_cnt_d;
      roi_q      <= roi_d;
      roi_we_q   <= roi_we_d;
      hit_q      <= hit_d;
      hit_we_q   <= hit_we_d;
      eof_q      <= eof_d;
      hist_q     <= hist_d;
      busy_q     <= busy_d;
    end
  end

  lsf_sat_counter #(.W(CNT_W)) u_slc_drop (
    .clock(clock), .reset(reset), .inc(inc_slc_drop), .count(o_slc_drop_cnt)
  );
  lsf_sat_counter #(.W(CNT_W)) u_hit_drop (
    .clock(clock), .reset(reset), .inc(inc_hit_drop), .count(o_hit_drop_cnt)
  );
  lsf_sat_counter #(.W(CNT_W)) u_orphan (
    .clock(clock), .reset(reset), .inc(inc_orphan), .count(o_orphan_hit_cnt)
  );

  assign o_roi        = roi_q;
  assign o_roi_we     = roi_we_q;
  assign o_mdt_hit    = hit_q;
  assign o_mdt_hit_we = hit_we_q;
  assign o_eof        = eof_q;
  assign o_hist_count = hist_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_lsf_event_sequencer.sv
// Bench for lsf_event_sequencer: table-driven events plus hand sequences, with a
// cycle-stamped scoreboard of expected ROI/hit/EOF outputs checked every clock.
module tb_lsf_event_sequencer;
  import lsf_seq_pkg::*;

  localparam int MAX_HITS      = 32;
  localparam int WINDOW_CYCLES = 64;
  localparam int MIN_GAP       = 4;
  localparam int CNT_W         = 4;
  localparam logic [63:0] HIT_MASK = (64'd1 << HEG2SFHIT_LEN) - 64'd1;

  typedef enum int {K_NONE, K_ROI, K_HIT, K_EOF, K_MULTI} kind_e;

  typedef struct {
    int          kind;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int n_hits;
    int hit_start;
    int eof_at;      // -1: no HEG EOF, window times out
    int exp_hist;
    int exp_drop;
    int exp_orphan;
  } vec_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [HEG2SFSLC_LEN-1:0] i_slc;
  logic                     i_slc_vld;
  logic [HEG2SFHIT_LEN-1:0] i_hit;
  logic                     i_hit_vld;
  logic                     i_heg_eof;
  logic [HEG2SFSLC_LEN-1:0] o_roi;
  logic                     o_roi_we;
  logic [HEG2SFHIT_LEN-1:0] o_mdt_hit;
  logic                     o_mdt_hit_we;
  logic                     o_eof;
  logic [HIST_CNT_W-1:0]    o_hist_count;
  logic [CNT_W-1:0]         o_slc_drop_cnt;
  logic [CNT_W-1:0]         o_hit_drop_cnt;
  logic [CNT_W-1:0]         o_orphan_hit_cnt;
  logic                     o_busy;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  lsf_event_sequencer #(
    .MAX_HITS(MAX_HITS), .WINDOW_CYCLES(WINDOW_CYCLES), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .i_slc(i_slc), .i_slc_vld(i_slc_vld), .i_hit(i_hit), .i_hit_vld(i_hit_vld),
    .i_heg_eof(i_heg_eof),
    .o_roi(o_roi), .o_roi_we(o_roi_we), .o_mdt_hit(o_mdt_hit), .o_mdt_hit_we(o_mdt_hit_we),
    .o_eof(o_eof), .o_hist_count(o_hist_count),
    .o_slc_drop_cnt(o_slc_drop_cnt), .o_hit_drop_cnt(o_hit_drop_cnt),
    .o_orphan_hit_cnt(o_orphan_hit_cnt), .o_busy(o_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 20000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Inputs set here are sampled at the next rising edge; returns at the following falling edge.
  task automatic drive(input bit sv, input bit hv, input bit ev,
                       input logic [63:0] sd, input logic [63:0] hd);
    i_slc_vld = sv;
    i_slc     = sd[HEG2SFSLC_LEN-1:0];
    i_hit_vld = hv;
    i_hit     = hd[HEG2SFHIT_LEN-1:0];
    i_heg_eof = ev;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_slc_vld = 1'b0; i_hit_vld = 1'b0; i_heg_eof = 1'b0; i_slc = '0; i_hit = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_idle_counters(input string tag, input int slc_d, input int hit_d,
                                     input int orph);
    check({tag, "_slc_drop"},   64'(o_slc_drop_cnt),   64'(slc_d));
    check({tag, "_hit_drop"},   64'(o_hit_drop_cnt),   64'(hit_d));
    check({tag, "_orphan"},     64'(o_orphan_hit_cnt), 64'(orph));
    check({tag, "_busy"},       64'(o_busy),           64'd0);
  endtask

  // Every clock: any write strobe, or any expectation due now, is compared against the scoreboard.
  always @(negedge clock) begin
    int          ak;
    logic [63:0] ad;
    exp_t        e;
    bit          due;
    ak = K_NONE;
    ad = '0;
    if ((int'(o_roi_we) + int'(o_mdt_hit_we) + int'(o_eof)) > 1) ak = K_MULTI;
    else if (o_roi_we)     begin ak = K_ROI; ad = 64'(o_roi);        end
    else if (o_mdt_hit_we) begin ak = K_HIT; ad = 64'(o_mdt_hit);    end
    else if (o_eof)        begin ak = K_EOF; ad = 64'(o_hist_count); end
    due = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
    if (due) e = exp_q.pop_front();
    else begin e.kind = K_NONE; e.data = '0; e.cyc = cyc; end
    if ((ak != K_NONE) || due) begin
      check($sformatf("out_kind@%0d", cyc), 64'(ak), 64'(e.kind));
      if (ak == e.kind) check($sformatf("out_data@%0d", cyc), ad, e.data);
    end
  end

  initial begin
    vec_t        vt[8];
    int          t0, close_c, fwd, end_c, last_c;
    logic [63:0] sd, hd;
    bit          hv;

    vt[0] = '{5,  2,  7,  5,  0,  0};   // basic event
    vt[1] = '{40, 2,  42, 32, 8,  0};   // hit cap
    vt[2] = '{0,  0,  -1, 0,  0,  0};   // empty window, timeout
    vt[3] = '{3,  1,  3,  3,  0,  0};   // hit in the close cycle counts
    vt[4] = '{4,  1,  2,  2,  0,  2};   // hits in CLOSE/GAP are orphans
    vt[5] = '{10, 60, -1, 5,  0,  5};   // hits straddling the timeout
    vt[6] = '{49, 1,  50, 32, 15, 0};   // hit-drop counter saturates at 2**CNT_W-1
    vt[7] = '{3,  0,  5,  2,  0,  1};   // hit alongside the ROI strobe is an orphan

    reset = 1'b1;
    i_slc_vld = 1'b0; i_hit_vld = 1'b0; i_heg_eof = 1'b0; i_slc = '0; i_hit = '0;
    repeat (3) @(negedge clock);
    check("rst_roi_we",  64'(o_roi_we),     64'd0);
    check("rst_hit_we",  64'(o_mdt_hit_we), 64'd0);
    check("rst_eof",     64'(o_eof),        64'd0);
    check("rst_hist",    64'(o_hist_count), 64'd0);
    check("rst_roi",     64'(o_roi),        64'd0);
    check("rst_hit",     64'(o_mdt_hit),    64'd0);
    check_idle_counters("rst", 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vt[i]) begin
      do_reset();
      t0      = cyc;
      close_c = (vt[i].eof_at >= 0) ? vt[i].eof_at : WINDOW_CYCLES;
      last_c  = vt[i].hit_start + vt[i].n_hits - 1;
      end_c   = ((close_c > last_c) ? close_c : last_c) + MIN_GAP + 4;
      fwd     = 0;
      for (int c = 0; c <= end_c; c++) begin
        sd = rnd64();
        hd = rnd64() & HIT_MASK;
        hv = (c >= vt[i].hit_start) && (c < vt[i].hit_start + vt[i].n_hits);
        if (c == 0) push(K_ROI, sd, t0 + 1);
        if (hv && (c >= 1) && (c <= close_c) && (fwd < MAX_HITS)) begin
          push(K_HIT, hd, t0 + c + 1);
          fwd++;
        end
        if (c == close_c) push(K_EOF, 64'(fwd), t0 + c + 2);
        drive(c == 0, hv, c == vt[i].eof_at, sd, hd);
      end
      check($sformatf("v%0d_hist", i), 64'(o_hist_count), 64'(vt[i].exp_hist));
      check_idle_counters($sformatf("v%0d", i), 0, vt[i].exp_drop, vt[i].exp_orphan);
    end

    // Pending slot: B held, C dropped, D arrives in IDLE beside B and takes the freed slot.
    begin
      logic [63:0] roi_b, roi_d;
      roi_b = '0;
      roi_d = '0;
      do_reset();
      t0 = cyc;
      for (int c = 0; c <= 34; c++) begin
        sd = rnd64();
        if (c == 3)  roi_b = sd;
        if (c == 14) roi_d = sd;
        if (c == 0)  push(K_ROI, sd, t0 + 1);
        if (c == 8)  begin push(K_EOF, 64'd0, t0 + 10); push(K_ROI, roi_b, t0 + 15); end
        if (c == 18) begin push(K_EOF, 64'd0, t0 + 20); push(K_ROI, roi_d, t0 + 25); end
        if (c == 27) push(K_EOF, 64'd0, t0 + 29);
        if (c == 12) check("pend_busy_gap", 64'(o_busy), 64'd1);
        if (c == 14) check("pend_busy_idle", 64'(o_busy), 64'd1);
        drive((c == 0) || (c == 3) || (c == 5) || (c == 14), 1'b0,
              (c == 8) || (c == 18) || (c == 27), sd, '0);
      end
      check_idle_counters("pend", 1, 0, 0);
    end

    // Hits with no open window, plus a stray HEG EOF that must be ignored.
    do_reset();
    for (int c = 0; c < 13; c++) drive(1'b0, c < 10, c == 4, '0, rnd64() & HIT_MASK);
    check("orph_hist", 64'(o_hist_count), 64'd0);
    check_idle_counters("orph", 0, 0, 10);

    // Reset in the middle of an open window aborts the event with no EOF.
    do_reset();
    t0 = cyc;
    for (int c = 0; c <= 5; c++) begin
      sd = rnd64();
      hd = rnd64() & HIT_MASK;
      hv = (c >= 2) && (c <= 4);
      if (c == 0) push(K_ROI, sd, t0 + 1);
      if (hv) push(K_HIT, hd, t0 + c + 1);
      drive(c == 0, hv, 1'b0, sd, hd);
    end
    reset = 1'b1;
    i_slc_vld = 1'b0; i_hit_vld = 1'b0; i_heg_eof = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, 1'b1, '0, '0);
    check("abort_hist", 64'(o_hist_count), 64'd0);
    check("abort_roi",  64'(o_roi),        64'd0);
    check("abort_hit",  64'(o_mdt_hit),    64'd0);
    check_idle_counters("abort", 0, 0, 0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
